im_loader: RTL and testbench

//  Boot-time writer for the instruction memory: accepts a byte stream (e.g. from a

---
 rtl/im_loader_if.sv | 25 ++
 rtl/im_loader.sv | 102 ++++++++++
 tb/tb_im_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Byte-stream in / instruction-memory write port out for the boot loader.
// The slave modport is the loader; the master modport is the stream source and IM/CPU side.
interface im_loader_if #(
  parameter int AW = 12
) ();
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic          hold;
  logic          load_done;
  logic          err;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, im_we, im_waddr, im_wdata, hold, load_done, err
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, im_we, im_waddr, im_wdata, hold, load_done, err
  );
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses big-endian {START, COUNT} segment
// headers from a byte stream and writes 32-bit words, holding the CPU until a terminator.
module im_loader #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  im_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HDR,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH17 = 17'(DEPTH);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_cnt;
  logic [31:0]   r_shift;
  logic [AW-1:0] r_waddr;
  logic [15:0]   r_remaining;
  logic          r_load_done;

  logic          w_accept;
  logic [15:0]   w_start;
  logic [15:0]   w_count;
  logic [16:0]   w_end;

  assign w_accept = bus.byte_valid & bus.byte_ready;
  assign w_start  = r_shift[31:16];
  assign w_count  = r_shift[15:0];
  // 17-bit sum so a segment ending exactly at DEPTH is distinguishable from overflow.
  assign w_end    = {1'b0, w_start} + {1'b0, w_count};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR:   if (w_accept && r_cnt == 2'd3) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_count == 16'd0)     w_state_nxt = S_DONE;
        else if (w_end > DEPTH17) w_state_nxt = S_ERR;
        else                      w_state_nxt = S_DATA;
      end
      S_DATA:  if (w_accept && r_cnt == 2'd3) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_remaining == 16'd1) ? S_HDR : S_DATA;
      S_DONE:  w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Header and data bytes share one shift register; the 2-bit counter wraps every 4 bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 2'd0;
      r_shift     <= 32'd0;
      r_waddr     <= '0;
      r_remaining <= 16'd0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= (r_state == S_CHECK) && (w_count == 16'd0);
      if (w_accept) begin
        r_shift <= {r_shift[23:0], bus.byte_in};
        r_cnt   <= r_cnt + 2'd1;
      end
      if (r_state == S_CHECK) begin
        r_waddr     <= w_start[AW-1:0];
        r_remaining <= w_count;
      end
      if (r_state == S_WRITE) begin
        r_waddr     <= r_waddr + 1'b1;
        r_remaining <= r_remaining - 16'd1;
      end
    end
  end

  assign bus.byte_ready = (r_state == S_HDR) || (r_state == S_DATA);
  assign bus.im_we      = (r_state == S_WRITE);
  assign bus.im_waddr   = r_waddr;
  // During WRITE the shift register holds the just-assembled word.
  assign bus.im_wdata   = r_shift;
  assign bus.hold       = (r_state != S_DONE);
  assign bus.load_done  = r_load_done;
  assign bus.err        = (r_state == S_ERR);

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: expected writes are queued as stimulus is driven
// and popped by a monitor when the loader pulses im_we.
module tb_im_loader;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic clk = 1'b0;
  logic reset;

  im_loader_if #(.AW(AW)) bus ();

  im_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] im_model [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wr_t e;
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_we_addr", {52'd0, bus.im_waddr}, 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", {52'd0, bus.im_waddr}, {52'd0, e.addr});
        check("we_data", {32'd0, bus.im_wdata}, {32'd0, e.data});
        im_model[bus.im_waddr] = bus.im_wdata;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold",      {63'd0, bus.hold},       64'd1);
    check("rst_ready",     {63'd0, bus.byte_ready}, 64'd1);
    check("rst_we",        {63'd0, bus.im_we},      64'd0);
    check("rst_err",       {63'd0, bus.err},        64'd0);
    check("rst_load_done", {63'd0, bus.load_done},  64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 100) check("ready_timeout", {63'd0, bus.byte_ready}, 64'd1);
    else begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] start, input logic [15:0] count, input int gmax);
    logic [31:0] h;
    h = {start, count};
    for (int i = 3; i >= 0; i--) send_byte(h[i*8 +: 8], $urandom_range(0, gmax));
  endtask

  // Queues the expected write, sends the word, and checks the one-cycle write latency.
  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w, input int gmax);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(0, gmax));
    check("we_latency", {63'd0, bus.im_we}, 64'd1);
  endtask

  task automatic idle_bytes(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.byte_in    = 8'(i * 37);
      bus.byte_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int we_before;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    reset          = 1'b1;

    // Reset values.
    do_reset();
    check("rst_waddr", {52'd0, bus.im_waddr}, 64'd0);
    check("rst_wdata", {32'd0, bus.im_wdata}, 64'd0);

    // Two-word segment at address 0, back-to-back bytes.
    send_hdr(16'h0000, 16'h0002, 0);
    send_word(12'h000, 32'h2401_0005, 0);
    send_word(12'h001, 32'h0000_0008, 0);

    // Overlapping segments to word 5: later write wins.
    send_hdr(16'h0005, 16'h0001, 1);
    send_word(12'h005, 32'h1111_1111, 1);
    send_hdr(16'h0005, 16'h0001, 1);
    send_word(12'h005, 32'h2222_2222, 1);

    // Random gaps on byte_valid.
    send_hdr(16'h0460, 16'h0001, 4);
    send_word(12'h460, 32'h4200_0018, 4);

    // Terminator: CHECK cycle, then one-cycle load_done with hold released.
    send_hdr(16'h0000, 16'h0000, 2);
    @(negedge clk);
    check("term_check_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("term_check_done",  {63'd0, bus.load_done},  64'd0);
    @(negedge clk);
    check("done_pulse", {63'd0, bus.load_done},  64'd1);
    check("done_hold",  {63'd0, bus.hold},       64'd0);
    check("done_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("done_err",   {63'd0, bus.err},        64'd0);
    @(negedge clk);
    check("done_pulse_end", {63'd0, bus.load_done}, 64'd0);
    we_before = we_count;
    idle_bytes(12);
    @(negedge clk);
    check("done_no_writes", 64'(we_count), 64'(we_before));
    check("done_hold_stays", {63'd0, bus.hold}, 64'd0);
    check("model_w0", {32'd0, im_model[0]},      64'h2401_0005);
    check("model_w1", {32'd0, im_model[1]},      64'h0000_0008);
    check("model_w5", {32'd0, im_model[5]},      64'h2222_2222);
    check("model_w460", {32'd0, im_model[12'h460]}, 64'h4200_0018);

    // Range error: 0xFFF + 2 > DEPTH.
    do_reset();
    send_hdr(16'h0FFF, 16'h0002, 0);
    repeat (2) @(negedge clk);
    check("err_flag",  {63'd0, bus.err},        64'd1);
    check("err_hold",  {63'd0, bus.hold},       64'd1);
    check("err_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("err_done",  {63'd0, bus.load_done},  64'd0);
    we_before = we_count;
    idle_bytes(10);
    @(negedge clk);
    check("err_no_writes", 64'(we_count), 64'(we_before));
    check("err_sticky", {63'd0, bus.err}, 64'd1);

    // Last legal word address.
    do_reset();
    send_hdr(16'h0FFF, 16'h0001, 0);
    send_word(12'hFFF, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("top_no_err", {63'd0, bus.err}, 64'd0);

    // Reset in the middle of a segment discards the partial word.
    send_hdr(16'h0020, 16'h0001, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    we_before = we_count;
    do_reset();
    check("midrst_no_write", 64'(we_count), 64'(we_before));
    send_hdr(16'h0010, 16'h0001, 1);
    send_word(12'h010, 32'hAABB_CCDD, 1);

    repeat (3) @(negedge clk);
    check("sb_empty",    64'(exp_q.size()), 64'd0);
    check("total_writes", 64'(we_count),    64'd7);
    check("model_w10",  {32'd0, im_model[12'h010]}, 64'hAABB_CCDD);
    check("model_wfff", {32'd0, im_model[12'hFFF]}, 64'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
